// File: rtl/cam_pkg.sv
// Shared CAM constants and the responder-sequencer state encoding.
// The tag register array and the read-out path import this package as well.
package cam_pkg;

  localparam int N_WORDS = 100;
  localparam int IDX_W   = 7;
  localparam int CNT_W   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lowest_one_encoder.sv
// Combinational priority encoder: reports the index of the lowest set bit,
// whether any bit is set, and whether exactly one bit is set.
module lowest_one_encoder
  import cam_pkg::*;
(
  input  logic [N_WORDS-1:0] i_vec,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_any,
  output logic               o_one
);

  logic [N_WORDS-1:0] w_low_cleared;

  // Walking downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_index = '0;
    for (int i = N_WORDS - 1; i >= 0; i--) begin
      if (i_vec[i]) o_index = IDX_W'(i);
    end
  end

  assign w_low_cleared = i_vec & (i_vec - N_WORDS'(1));
  assign o_any         = |i_vec;
  assign o_one         = o_any && (w_low_cleared == '0);

endmodule

// File: rtl/responder_sequencer.sv
// Snapshots the tag vector and presents tagged word indices one per
// valid/ready handshake, lowest index first, with count and some/none status.
module responder_sequencer
  import cam_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic               abort,
  input  logic [N_WORDS-1:0] tags_in,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDX_W-1:0]   resp_index,
  output logic               resp_last,
  output logic               busy,
  output logic               some_none,
  output logic [CNT_W-1:0]   resp_count,
  output logic               done
);

  state_t             r_state;
  logic [N_WORDS-1:0] r_pending;
  logic               r_some;
  logic [CNT_W-1:0]   r_count;

  logic [IDX_W-1:0]   w_index;
  logic               w_any;
  logic               w_one;
  logic               w_fire;

  lowest_one_encoder u_encoder (
    .i_vec   (r_pending),
    .o_index (w_index),
    .o_any   (w_any),
    .o_one   (w_one)
  );

  assign w_fire = resp_valid && resp_ready;

  // NOTE: reset is sampled on the clock edge and all state uses <= so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_some    <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!abort && start) begin
            r_pending <= tags_in;
            r_some    <= |tags_in;
            r_count   <= '0;
            r_state   <= (|tags_in) ? SCAN : DONE;
          end
        end
        SCAN: begin
          if (abort) begin
            r_pending <= '0;
            r_state   <= IDLE;
          end else if (w_fire) begin
            // Clearing the lowest set bit retires exactly the presented index.
            r_pending <= r_pending & (r_pending - N_WORDS'(1));
            r_count   <= r_count + CNT_W'(1);
            if (w_one) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (r_state == SCAN) && w_any;
  assign resp_index = w_index;
  assign resp_last  = (r_state == SCAN) && w_one;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign some_none  = r_some;
  assign resp_count = r_count;

endmodule
